// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI host sequencer.
package spi_pkg;

   localparam int SPI_BYTE_W  = 8;
   localparam int BIT_CNT_W   = $clog2(SPI_BYTE_W);
   localparam int CLK_DIV_DEF = 4;
   localparam int LEN_W_DEF   = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      TAIL,
      GAP
   } state_e;

endpackage

// File: rtl/spi_host_sequencer_if.sv
// Host-engine side of the sequencer: transaction request plus tx/rx byte streams.
interface spi_host_sequencer_if #(
   parameter int LEN_W = 4
);
   import spi_pkg::*;

   logic                  start;
   logic [LEN_W-1:0]      len;
   logic                  busy;
   logic [SPI_BYTE_W-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [SPI_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic                  done;

   modport master (
      output start, len, tx_data, tx_valid,
      input  busy, tx_ready, rx_data, rx_valid, done
   );

   modport slave (
      input  start, len, tx_data, tx_valid,
      output busy, tx_ready, rx_data, rx_valid, done
   );

endinterface

// File: rtl/spi_sck_gen.sv
// Half-period divider: tick every CLK_DIV enabled clocks; SCK toggles on ticks when sck_en_i.
module spi_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic sck_en_i,
   output logic sck_o,
   output logic tick_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;

   assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
   assign rise_o = tick_o && sck_en_i && !sck_q;
   assign fall_o = tick_o && sck_en_i && sck_q;
   assign sck_o  = sck_q;

   always_comb begin
      cnt_d = '0;
      sck_d = sck_q;
      if (en_i && !tick_o) cnt_d = cnt_q + 1'b1;
      // Dropping the enable parks SCK low so stalls never leave a stray edge.
      if (!en_i)                    sck_d = 1'b0;
      else if (tick_o && sck_en_i)  sck_d = ~sck_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/spi_host_sequencer.sv
// Mode-0, MSB-first SPI host: sequences len bytes per CS_n assertion from a tx stream.
module spi_host_sequencer
   import spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   spi_host_sequencer_if.slave host_if,
   output logic                SCK,
   output logic                CS_n,
   output logic                COPI,
   input  logic                POCI
);
   state_e                state_q, state_d;
   logic [LEN_W-1:0]      remaining_q, remaining_d;
   logic [SPI_BYTE_W-1:0] shift_q, shift_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  cs_n_q, cs_n_d;
   logic                  copi_q, copi_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  done_q, done_d;
   logic                  div_en, sck_en, tick, sck_rise, sck_fall;

   assign div_en = state_q inside {SHIFT, TAIL, GAP};
   assign sck_en = (state_q == SHIFT);

   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (div_en),
      .sck_en_i (sck_en),
      .sck_o    (SCK),
      .tick_o   (tick),
      .rise_o   (sck_rise),
      .fall_o   (sck_fall)
   );

   assign CS_n             = cs_n_q;
   assign COPI             = copi_q;
   assign host_if.busy     = (state_q != IDLE);
   assign host_if.tx_ready = (state_q == LOAD);
   assign host_if.rx_data  = rx_data_q;
   assign host_if.rx_valid = rx_valid_q;
   assign host_if.done     = done_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      bit_cnt_d   = bit_cnt_q;
      cs_n_d      = cs_n_q;
      copi_d      = copi_q;
      rx_valid_d  = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (host_if.start && host_if.len != '0) begin
            remaining_d = host_if.len;
            state_d     = LOAD;
         end
         LOAD: if (host_if.tx_valid) begin
            shift_d   = host_if.tx_data;
            copi_d    = host_if.tx_data[SPI_BYTE_W-1];
            cs_n_d    = 1'b0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            // tx bits leave from the MSB while rx bits enter at the LSB.
            if (sck_rise) shift_d = {shift_q[SPI_BYTE_W-2:0], POCI};
            if (sck_fall) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_CNT_W'(SPI_BYTE_W - 1)) begin
                  rx_data_d   = shift_q;
                  rx_valid_d  = 1'b1;
                  remaining_d = remaining_q - 1'b1;
                  state_d     = (remaining_q == LEN_W'(1)) ? TAIL : LOAD;
               end else begin
                  copi_d = shift_q[SPI_BYTE_W-1];
               end
            end
         end
         TAIL: if (tick) begin
            cs_n_d  = 1'b1;
            state_d = GAP;
         end
         GAP: if (tick) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         bit_cnt_q   <= '0;
         cs_n_q      <= 1'b1;
         copi_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         bit_cnt_q   <= bit_cnt_d;
         cs_n_q      <= cs_n_d;
         copi_q      <= copi_d;
         rx_valid_q  <= rx_valid_d;
         done_q      <= done_d;
      end
   end

endmodule
